// File: rtl/fp_mac_sequencer.sv
// Host-side byte-serial controller for the floating-point MAC datapath: loads operands,
// issues start/clear pulses, waits for done with a timeout and streams the accumulator back.
module fp_mac_sequencer #(
    parameter int unsigned W           = 16,
    parameter int unsigned MAC_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic [1:0]   in_cmd,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ack,
    output logic         busy,
    output logic         err,
    output logic [7:0]   op_count,
    output logic [W-1:0] mac_a,
    output logic [W-1:0] mac_b,
    output logic         mac_start,
    output logic         mac_clear,
    input  logic         mac_done,
    input  logic [W-1:0] mac_acc
);
    localparam int unsigned NumBytes = W / 8;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(NumBytes - 1);
    localparam logic [7:0]      TimeoutLast = 8'(MAC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StLoadA, StLoadB, StIssue, StWait, StClr, StRead
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [W-1:0]    mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [7:0]      op_count_q, op_count_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            err_q, err_d;
    logic            start_q, start_d;
    logic            clear_q, clear_d;
    logic            xfer;
    logic [IdxW-1:0] idx_nxt;

    assign in_ready  = (state_q == StIdle) || (state_q == StLoadA) || (state_q == StLoadB);
    assign busy      = (state_q != StIdle);
    assign xfer      = in_valid & in_ready;
    assign idx_nxt   = idx_q + 1'b1;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign op_count  = op_count_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_start = start_q;
    assign mac_clear = clear_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        op_count_d  = op_count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        start_d     = 1'b0;
        clear_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (xfer) begin
                    case (in_cmd)
                        2'b01: begin
                            state_d = StLoadA;
                            idx_d   = '0;
                        end
                        2'b10: begin
                            state_d = StClr;
                            clear_d = 1'b1;
                        end
                        2'b11: begin
                            // Snapshot so later accumulator activity cannot tear the readout
                            shadow_d    = mac_acc;
                            out_data_d  = mac_acc[7:0];
                            out_valid_d = 1'b1;
                            idx_d       = '0;
                            state_d     = StRead;
                        end
                        default: ;
                    endcase
                end
            end
            StLoadA: begin
                if (xfer) begin
                    mac_a_d[int'(idx_q)*8 +: 8] = in_data;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StLoadB;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            StLoadB: begin
                if (xfer) begin
                    mac_b_d[int'(idx_q)*8 +: 8] = in_data;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StIssue;
                        start_d = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (mac_done) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StClr: begin
                err_d      = 1'b0;
                op_count_d = '0;
                state_d    = StIdle;
            end
            StRead: begin
                if (out_ack && out_valid_q) begin
                    if (idx_q == LastIdx) begin
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                        state_d     = StIdle;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = shadow_q[int'(idx_nxt)*8 +: 8];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            op_count_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            op_count_q  <= op_count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            start_q     <= start_d;
            clear_q     <= clear_d;
        end
    end

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Directed self-checking bench for fp_mac_sequencer (W=16, MAC_TIMEOUT=15).
module tb_fp_mac_sequencer;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic [1:0]   in_cmd;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ack;
    logic         busy;
    logic         err;
    logic [7:0]   op_count;
    logic [W-1:0] mac_a;
    logic [W-1:0] mac_b;
    logic         mac_start;
    logic         mac_clear;
    logic         mac_done;
    logic [W-1:0] mac_acc;

    int n_checks = 0;
    int n_err    = 0;
    int n_start  = 0;
    int n_clear  = 0;
    int s0;
    logic [7:0] exp_ops;

    fp_mac_sequencer #(.W(W), .MAC_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_cmd    (in_cmd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .busy      (busy),
        .err       (err),
        .op_count  (op_count),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_start (mac_start),
        .mac_clear (mac_clear),
        .mac_done  (mac_done),
        .mac_acc   (mac_acc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mac_start === 1'b1) n_start++;
        if (mac_clear === 1'b1) n_clear++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] data);
        in_cmd   = cmd;
        in_data  = data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_cmd = '0; in_valid = 1'b0;
        out_ack = 1'b0; mac_done = 1'b0; mac_acc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_opcnt", 32'(op_count), 0);
        chk("rst_outvalid", 32'(out_valid), 0);

        // Reset mid-LOAD_B after one B byte
        send(2'b01, 8'h00); send(2'b00, 8'h80); send(2'b00, 8'h3F);
        chk("loadb_busy", 32'(busy), 1);
        chk("loadb_mac_a", 32'(mac_a), 32'h3F80);
        send(2'b00, 8'h11);
        chk("loadb_mac_b", 32'(mac_b), 32'h0011);
        s0 = n_start;
        rst = 1'b1;
        #2;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(in_ready), 1);
        chk("arst_mac_a", 32'(mac_a), 0);
        chk("arst_mac_b", 32'(mac_b), 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("arst_no_start", 32'(n_start - s0), 0);
        chk("arst_idle", 32'(busy), 0);

        // MAC: A=0x3F80, B=0x4000, done 3 cycles after start
        s0 = n_start;
        send(2'b01, 8'h00); send(2'b00, 8'h80); send(2'b00, 8'h3F);
        send(2'b00, 8'h00);
        chk("mac_no_early_start", 32'(mac_start), 0);
        send(2'b00, 8'h40);
        chk("mac_start", 32'(mac_start), 1);
        chk("mac_ready_issue", 32'(in_ready), 0);
        chk("mac_a", 32'(mac_a), 32'h3F80);
        chk("mac_b", 32'(mac_b), 32'h4000);
        tick();
        chk("mac_start_drop", 32'(mac_start), 0);
        tick();
        tick();
        mac_done = 1'b1;
        chk("mac_busy_at_done", 32'(busy), 1);
        tick();
        mac_done = 1'b0;
        chk("mac_busy_fall", 32'(busy), 0);
        chk("mac_opcnt", 32'(op_count), 1);
        chk("mac_err", 32'(err), 0);
        chk("mac_one_start", 32'(n_start - s0), 1);

        // Timeout: done never arrives
        send(2'b01, 8'h00); send(2'b00, 8'h01); send(2'b00, 8'h00);
        send(2'b00, 8'h02); send(2'b00, 8'h00);
        tick();
        repeat (14) tick();
        chk("to_err_early", 32'(err), 0);
        chk("to_busy_early", 32'(busy), 1);
        tick();
        chk("to_err", 32'(err), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_opcnt", 32'(op_count), 1);

        // CLEAR after timeout
        s0 = n_clear;
        send(2'b10, 8'h00);
        chk("clr_pulse", 32'(mac_clear), 1);
        tick();
        chk("clr_pulse_drop", 32'(mac_clear), 0);
        chk("clr_one_pulse", 32'(n_clear - s0), 1);
        chk("clr_err", 32'(err), 0);
        chk("clr_opcnt", 32'(op_count), 0);
        chk("clr_idle", 32'(busy), 0);

        // Done on the same cycle the timeout would fire
        send(2'b01, 8'h00); send(2'b00, 8'h01); send(2'b00, 8'h00);
        send(2'b00, 8'h02); send(2'b00, 8'h00);
        tick();
        repeat (14) tick();
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        chk("coll_err", 32'(err), 0);
        chk("coll_opcnt", 32'(op_count), 1);
        chk("coll_idle", 32'(busy), 0);
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        chk("done_outside_wait", 32'(op_count), 1);

        // READ with shadowed accumulator
        mac_acc = 16'h40A0;
        send(2'b11, 8'h00);
        mac_acc = 16'h1234;
        chk("rd_valid", 32'(out_valid), 1);
        chk("rd_byte0", 32'(out_data), 32'hA0);
        chk("rd_ready", 32'(in_ready), 0);
        repeat (3) tick();
        chk("rd_hold", 32'(out_data), 32'hA0);
        chk("rd_hold_valid", 32'(out_valid), 1);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("rd_byte1", 32'(out_data), 32'h40);
        chk("rd_valid1", 32'(out_valid), 1);
        tick();
        chk("rd_hold1", 32'(out_data), 32'h40);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("rd_done_valid", 32'(out_valid), 0);
        chk("rd_done_idle", 32'(busy), 0);

        // op_count wrap over 256 MACs with interleaved NOPs
        send(2'b10, 8'h00);
        tick();
        exp_ops = 8'h00;
        s0 = n_start;
        for (int i = 0; i < 256; i++) begin
            send(2'b01, 8'h00); send(2'b00, 8'(i)); send(2'b00, 8'hA5);
            send(2'b00, 8'h5A); send(2'b00, 8'(i));
            tick();
            mac_done = 1'b1;
            tick();
            mac_done = 1'b0;
            exp_ops = exp_ops + 8'd1;
            chk("wrap_opcnt", 32'(op_count), 32'(exp_ops));
            send(2'b00, 8'hFF);
            chk("nop_opcnt", 32'(op_count), 32'(exp_ops));
            chk("nop_idle", 32'(busy), 0);
        end
        chk("wrap_zero", 32'(op_count), 0);
        chk("wrap_starts", 32'(n_start - s0), 256);
        chk("nop_mac_a", 32'(mac_a), 32'hA5FF);
        chk("nop_mac_b", 32'(mac_b), 32'hFF5A);
        chk("nop_err", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/fp_mac_sequencer.md
Name: fp_mac_sequencer

Overview:
Host-side controller for the floating-point MAC datapath. Host uses the narrow 8-bit pin interface of the chip top. The block:
- assembles byte-serial operands A and B into full-width words;
- issues a single-cycle start to the MAC and waits for its done, with a timeout;
- clears the accumulator on command;
- streams the accumulator back out byte-serially.

It sits between the top-level pin mapping and the MAC core.

Parameters:
W, 16, operand/accumulator width in bits; multiple of 8, >= 8 (16 = bfloat16)
MAC_TIMEOUT, 15, max cycles waited for mac_done after mac_start before flagging error (1..255)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  8  operand byte
in_cmd  input  2  command: 00 NOP, 01 MAC, 10 CLEAR, 11 READ
in_valid  input  1  host byte/command strobe
in_ready  output  1  block can accept a transfer this cycle
out_data  output  8  accumulator byte
out_valid  output  1  out_data valid
out_ack  input  1  host consumed out_data
busy  output  1  state != IDLE
err  output  1  sticky timeout flag
op_count  output  8  completed MAC operations, wraps
mac_a  output  W  operand A to datapath
mac_b  output  W  operand B to datapath
mac_start  output  1  one-cycle start pulse
mac_clear  output  1  one-cycle accumulator clear pulse
mac_done  input  1  datapath result accumulated
mac_acc  input  W  datapath accumulator value

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, ISSUE, WAIT, CLR, READ. Transfer = in_valid & in_ready on a rising edge.
- Reset (async, any state, mid-operation included):
  - state IDLE;
  - mac_a, mac_b, op_count, out_data, byte index, timeout counter all 0;
  - err 0; mac_start, mac_clear, out_valid 0;
  - no pulse is emitted on reset release.
- in_ready = 1 in IDLE, LOAD_A, LOAD_B; 0 otherwise. busy is combinational from state.
- IDLE: transfer decodes in_cmd; in_data is ignored.
  - NOP: stay IDLE.
  - MAC: go to LOAD_A, byte index 0.
  - CLEAR: go to CLR.
  - READ: capture mac_acc into a shadow register, go to READ.
- LOAD_A / LOAD_B: each transfer writes in_data into byte[idx] of mac_a / mac_b, LSB byte first. in_cmd is ignored.
  - After byte W/8-1, idx resets to 0 and the state advances (LOAD_A -> LOAD_B -> ISSUE).
  - Cycles without in_valid hold the state.
- ISSUE: mac_start = 1 for exactly this cycle; next state WAIT, timeout counter cleared. mac_a/mac_b hold stable from ISSUE until the next MAC load.
- WAIT: counter increments each cycle.
  - mac_done = 1: op_count += 1 (255 -> 0), go to IDLE.
  - Otherwise, when counter reaches MAC_TIMEOUT: err <= 1, op_count unchanged, go to IDLE.
  - mac_done in the same cycle the timeout is reached: done wins, err not set.
  - mac_done outside WAIT is ignored.
- Latency with a zero-wait datapath: mac_start is high 1 cycle after the last B byte transfer.
- CLR: mac_clear = 1 for exactly this cycle; err <= 0, op_count <= 0; next state IDLE. mac_clear is high the cycle after the command transfer.
- READ: out_valid = 1, out_data = shadow byte[idx], LSB byte first.
  - out_ack while out_valid advances idx.
  - Ack of byte W/8-1 returns to IDLE, out_valid 0 the next cycle.
  - out_data holds until acked.
  - Shadow value is unaffected by mac_acc changes during READ.
- All outputs are registered except in_ready and busy.

Test Plan:
- Reset then idle: assert rst mid-LOAD_B after one byte -> state IDLE, mac_a = 0, mac_b = 0, in_ready = 1, busy = 0; no mac_start pulse after release.
- MAC with W=16, mock datapath asserting done 3 cycles after start:
  - stimulus: cmd 01, then bytes 80, 3F (A = 0x3F80), then 00, 40 (B = 0x4000);
  - response: mac_a = 0x3F80, mac_b = 0x4000, one-cycle mac_start the cycle after byte 0x40, op_count = 1, busy falls the cycle after done.
- Timeout: mock never asserts done -> err = 1 exactly MAC_TIMEOUT = 15 cycles after WAIT entry, op_count unchanged, back in IDLE.
  - Follow-up: CLEAR -> one-cycle mac_clear, err = 0, op_count = 0.
- Done/timeout collision: done asserted on cycle 15 of WAIT -> err = 0, op_count incremented.
- READ with mac_acc = 0x40A0:
  - response: out_data 0xA0 held for 3 cycles with no ack, then 0x40 after ack;
  - changing mac_acc to 0x1234 mid-read does not alter output;
  - return to IDLE after second ack.
- op_count wrap: 256 MAC operations -> op_count = 0; NOP commands interleaved leave all state unchanged.
